// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state and access owner encodings.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  // Encoding doubles as the bit index into the {data, fetch} request vector.
  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick. req[0] = fetch, req[1] = data.
// On a tie the requester that was not served last wins.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic       valid,
  output owner_t     pick
);

  // Single request wins outright; both requesting alternates against last_owner.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block leaves a latch behind.
    valid = |req;
    pick  = OWN_FETCH;
    if (req == 2'b11) begin
      pick = other_owner(last_owner);
    end else if (req[1]) begin
      pick = OWN_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Each access runs IDLE -> SETUP -> STROBE (STROBE_CYCLES) -> ACK -> IDLE.
// mem_clock, mem_write and the acks are registered so the memory strobe is glitch-free.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_address,
  output logic                  fetch_ack,
  output logic [DATA_WIDTH-1:0] fetch_data,
  input  logic                  data_req,
  input  logic                  data_write,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_ack,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] to_mem,
  output logic                  mem_clock,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] from_mem,
  output logic                  busy
);

  localparam int              CNT_W    = $clog2(STROBE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);

  state_t           state, state_next;
  owner_t           owner, owner_next;
  owner_t           last_owner;
  logic [CNT_W-1:0] strobe_cnt;
  logic             strobe_done;
  logic             grant_valid;
  owner_t           grant_pick;

  rr_pick2 u_pick (
    .req        ({data_req, fetch_req}),
    .last_owner (last_owner),
    .valid      (grant_valid),
    .pick       (grant_pick)
  );

  assign strobe_done = (state == ST_STROBE) && (strobe_cnt == CNT_LAST);
  assign busy        = (state != ST_IDLE);

  // State, owner and round-robin history registers.
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous (sampled at the edge) and all state uses non-blocking assignment.
    if (!reset_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_FETCH;
      last_owner <= OWN_DATA;
    end else begin
      state <= state_next;
      owner <= owner_next;
      if (state == ST_ACK) begin
        last_owner <= owner;
      end
    end
  end

  // Next-state: arbitrate only in IDLE; SETUP and ACK last one cycle each.
  always_comb begin
    state_next = state;
    owner_next = owner;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          state_next = ST_SETUP;
          owner_next = grant_pick;
        end
      end
      ST_SETUP:  state_next = ST_STROBE;
      ST_STROBE: if (strobe_done) state_next = ST_ACK;
      ST_ACK:    state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Strobe length counter; held at zero outside STROBE so it starts clean on entry.
  always_ff @(posedge clock) begin
    if (!reset_n || state != ST_STROBE) begin
      strobe_cnt <= '0;
    end else begin
      strobe_cnt <= strobe_cnt + CNT_W'(1);
    end
  end

  // Memory-side outputs, read capture and ack pulses.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      address    <= '0;
      to_mem     <= '0;
      mem_write  <= 1'b0;
      mem_clock  <= 1'b0;
      fetch_ack  <= 1'b0;
      data_ack   <= 1'b0;
      fetch_data <= '0;
      data_rdata <= '0;
    end else begin
      if (state == ST_IDLE && grant_valid) begin
        address   <= (grant_pick == OWN_FETCH) ? fetch_address : data_address;
        mem_write <= (grant_pick == OWN_DATA) && data_write;
        if (grant_pick == OWN_DATA) begin
          to_mem <= data_wdata;
        end
      end else if (strobe_done) begin
        mem_write <= 1'b0;
      end

      if (strobe_done) begin
        if (owner == OWN_FETCH) begin
          fetch_data <= from_mem;
        end else if (!mem_write) begin
          data_rdata <= from_mem;
        end
      end

      mem_clock <= (state_next == ST_STROBE);
      fetch_ack <= (state_next == ST_ACK) && (owner == OWN_FETCH);
      data_ack  <= (state_next == ST_ACK) && (owner == OWN_DATA);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench: two arbiters (STROBE_CYCLES = 1 and 3), each with a small memory model.
// Expected acks are queued when a request is driven and popped when an ack appears.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct packed {
    logic [1:0] acks;   // {fetch_ack, data_ack}
    logic [7:0] fdata;
    logic [7:0] rdata;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n       [2];
  logic       fetch_req     [2];
  logic [7:0] fetch_address [2];
  logic       fetch_ack     [2];
  logic [7:0] fetch_data    [2];
  logic       data_req      [2];
  logic       data_write    [2];
  logic [7:0] data_address  [2];
  logic [7:0] data_wdata    [2];
  logic       data_ack      [2];
  logic [7:0] data_rdata    [2];
  logic [7:0] address       [2];
  logic [7:0] to_mem        [2];
  logic       mem_clock     [2];
  logic       mem_write     [2];
  logic       busy          [2];

  exp_t       sb [$];
  logic [7:0] shadow  [2][256];
  logic [7:0] m_fetch [2];
  logic [7:0] m_rdata [2];
  int         vectors = 0;
  int         errors  = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0]   from_mem = '0;
    logic [7:0]   mem [256];
    logic [255:0] written = '0;

    mem_port_arbiter #(
      .ADDR_WIDTH    (8),
      .DATA_WIDTH    (8),
      .STROBE_CYCLES ((g == 0) ? 1 : 3)
    ) dut (
      .clock         (clock),
      .reset_n       (reset_n[g]),
      .fetch_req     (fetch_req[g]),
      .fetch_address (fetch_address[g]),
      .fetch_ack     (fetch_ack[g]),
      .fetch_data    (fetch_data[g]),
      .data_req      (data_req[g]),
      .data_write    (data_write[g]),
      .data_address  (data_address[g]),
      .data_wdata    (data_wdata[g]),
      .data_ack      (data_ack[g]),
      .data_rdata    (data_rdata[g]),
      .address       (address[g]),
      .to_mem        (to_mem[g]),
      .mem_clock     (mem_clock[g]),
      .mem_write     (mem_write[g]),
      .from_mem      (from_mem),
      .busy          (busy[g])
    );

    // Memory acts on the rising edge of mem_clock; unwritten words read as addr ^ 0xC6.
    always @(posedge mem_clock[g]) begin
      if (mem_write[g]) begin
        mem[address[g]]     <= to_mem[g];
        written[address[g]] <= 1'b1;
      end
      from_mem <= written[address[g]] ? mem[address[g]] : (address[g] ^ 8'hC6);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_fetch(input int d, input logic [7:0] a);
    fetch_req[d]     = 1'b1;
    fetch_address[d] = a;
    m_fetch[d]       = shadow[d][a];
    sb.push_back('{acks: 2'b10, fdata: m_fetch[d], rdata: m_rdata[d]});
  endtask

  task automatic do_data(input int d, input logic wr, input logic [7:0] a, input logic [7:0] wd);
    data_req[d]     = 1'b1;
    data_write[d]   = wr;
    data_address[d] = a;
    data_wdata[d]   = wd;
    if (wr) shadow[d][a] = wd;
    else    m_rdata[d]   = shadow[d][a];
    sb.push_back('{acks: 2'b01, fdata: m_fetch[d], rdata: m_rdata[d]});
  endtask

  task automatic drop(input int d);
    fetch_req[d]  = 1'b0;
    data_req[d]   = 1'b0;
    data_write[d] = 1'b0;
  endtask

  task automatic do_reset(input int d);
    reset_n[d] = 1'b0;
    cycles(1);
    reset_n[d] = 1'b1;
    m_fetch[d] = 8'h00;
    m_rdata[d] = 8'h00;
  endtask

  // One cycle to let ACK return to IDLE, then confirm the arbiter is idle.
  task automatic idle_gap(input int d);
    cycles(1);
    check("idle_busy", 32'(busy[d]), 32'd0);
  endtask

  // Wait (bounded) for an ack, compare it with the scoreboard head.
  // exp_lat < 0 skips the latency and strobe-width checks.
  task automatic wait_ack(input int d, input int exp_lat, input int exp_clk, input int exp_wr);
    int cyc    = 0;
    int clk_hi = 0;
    int wr_hi  = 0;
    bit got    = 1'b0;
    exp_t e;
    while (!got && cyc < 20) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (mem_clock[d]) clk_hi++;
      if (mem_write[d]) wr_hi++;
      if (fetch_ack[d] || data_ack[d]) got = 1'b1;
    end
    check("ack_seen", 32'(got), 32'd1);
    if (!got) return;
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("ack_owner", 32'({fetch_ack[d], data_ack[d]}), 32'(e.acks));
    check("fetch_data", 32'(fetch_data[d]), 32'(e.fdata));
    check("data_rdata", 32'(data_rdata[d]), 32'(e.rdata));
    if (exp_lat >= 0) begin
      check("ack_latency", 32'(cyc), 32'(exp_lat));
      check("strobe_cycles", 32'(clk_hi), 32'(exp_clk));
      check("write_cycles", 32'(wr_hi), 32'(exp_wr));
    end
  endtask

  initial begin
    int extra;
    for (int d = 0; d < 2; d++) begin
      reset_n[d] = 1'b0;
      drop(d);
      fetch_address[d] = '0;
      data_address[d]  = '0;
      data_wdata[d]    = '0;
      m_fetch[d]       = '0;
      m_rdata[d]       = '0;
      for (int i = 0; i < 256; i++) shadow[d][i] = 8'(i) ^ 8'hC6;
    end
    cycles(2);

    // Reset state of both instances.
    for (int d = 0; d < 2; d++) begin
      check("rst_fetch_ack", 32'(fetch_ack[d]), 32'd0);
      check("rst_data_ack", 32'(data_ack[d]), 32'd0);
      check("rst_mem_clock", 32'(mem_clock[d]), 32'd0);
      check("rst_mem_write", 32'(mem_write[d]), 32'd0);
      check("rst_busy", 32'(busy[d]), 32'd0);
      check("rst_address", 32'(address[d]), 32'd0);
      check("rst_to_mem", 32'(to_mem[d]), 32'd0);
      check("rst_fetch_data", 32'(fetch_data[d]), 32'd0);
      check("rst_data_rdata", 32'(data_rdata[d]), 32'd0);
    end
    reset_n[0] = 1'b1;
    reset_n[1] = 1'b1;

    // Single fetch of 0x05 (0xC3).
    do_fetch(0, 8'h05);
    wait_ack(0, 3, 1, 0);
    drop(0);
    check("addr_hold", 32'(address[0]), 32'h05);
    idle_gap(0);

    // Data write 0xA5 to 0x10, then read it back.
    do_data(0, 1'b1, 8'h10, 8'hA5);
    wait_ack(0, 3, 1, 2);
    check("to_mem", 32'(to_mem[0]), 32'hA5);
    drop(0);
    idle_gap(0);
    do_data(0, 1'b0, 8'h10, 8'h00);
    wait_ack(0, 3, 1, 0);
    drop(0);
    idle_gap(0);

    // Tie after reset: fetch first, then alternation while both are held.
    do_reset(0);
    do_fetch(0, 8'h01);
    do_data(0, 1'b0, 8'h10, 8'h00);
    wait_ack(0, 3, 1, 0);
    do_fetch(0, 8'h01);
    wait_ack(0, 4, 1, 0);
    do_data(0, 1'b0, 8'h10, 8'h00);
    wait_ack(0, 4, 1, 0);
    wait_ack(0, 4, 1, 0);
    drop(0);
    idle_gap(0);

    // Data request arrives during a fetch strobe while fetch stays asserted.
    do_fetch(0, 8'h02);
    cycles(2);
    check("strobe_high", 32'(mem_clock[0]), 32'd1);
    do_data(0, 1'b0, 8'h10, 8'h00);
    wait_ack(0, -1, 0, 0);
    wait_ack(0, 4, 1, 0);
    drop(0);
    idle_gap(0);

    // Reset during STROBE aborts the access without an ack.
    do_fetch(0, 8'h07);
    cycles(2);
    reset_n[0] = 1'b0;
    drop(0);
    cycles(1);
    check("abort_mem_clock", 32'(mem_clock[0]), 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_mem_write", 32'(mem_write[0]), 32'd0);
    check("abort_acks", 32'({fetch_ack[0], data_ack[0]}), 32'd0);
    reset_n[0] = 1'b1;
    void'(sb.pop_back());
    m_fetch[0] = 8'h00;
    m_rdata[0] = 8'h00;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      if (fetch_ack[0] || data_ack[0]) extra++;
    end
    check("abort_no_ack", 32'(extra), 32'd0);
    do_fetch(0, 8'h05);
    wait_ack(0, 3, 1, 0);
    drop(0);
    idle_gap(0);

    // STROBE_CYCLES = 3: read, write, read back.
    do_data(1, 1'b0, 8'h33, 8'h00);
    wait_ack(1, 5, 3, 0);
    drop(1);
    idle_gap(1);
    do_data(1, 1'b1, 8'h33, 8'h77);
    wait_ack(1, 5, 3, 4);
    drop(1);
    idle_gap(1);
    do_data(1, 1'b0, 8'h33, 8'h00);
    wait_ack(1, 5, 3, 0);
    drop(1);
    idle_gap(1);

    // Fetch request dropped mid-access still gets exactly one ack.
    do_fetch(1, 8'h40);
    cycles(2);
    drop(1);
    wait_ack(1, -1, 0, 0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      cycles(1);
      if (fetch_ack[1] || data_ack[1]) extra++;
    end
    check("single_ack", 32'(extra), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
